// File: rtl/scale_cache_reader_if.sv
// Bundles the scale-cache read port and the pixel output stream of scale_cache_reader.
// master = reader side, slave = cache model / downstream consumer side.
interface scale_cache_reader_if #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned ROW_WIDTH  = 9,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 17
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_SIZE-1:0]  rd_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_SIZE-1:0]  out_pixel;
    logic [ROW_WIDTH-1:0]  out_x;
    logic [COL_WIDTH-1:0]  out_y;
    logic                  out_eol;
    logic                  out_eof;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output out_valid, out_pixel, out_x, out_y, out_eol, out_eof,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  out_valid, out_pixel, out_x, out_y, out_eol, out_eof,
        output out_ready
    );
endinterface

// File: rtl/scale_cache_reader.sv
// Raster-order reader for the scale-image cache: credit-limited reads into a 2-entry skid FIFO.
// Define SCALE_READER_CLAMP_EN to clamp the requested dims to ROW_SIZE x COL_SIZE at start.
module scale_cache_reader #(
    parameter int unsigned ROW_SIZE   = 320,
    parameter int unsigned COL_SIZE   = 240,
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned ROW_WIDTH  = $clog2(ROW_SIZE),
    parameter int unsigned COL_WIDTH  = $clog2(COL_SIZE),
    parameter int unsigned ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROW_WIDTH:0]   img_width,
    input  logic [COL_WIDTH:0]   img_height,
    output logic                 busy,
    output logic                 done,
    scale_cache_reader_if.master bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pixel;
        logic [ROW_WIDTH-1:0] x;
        logic [COL_WIDTH-1:0] y;
        logic                 eol;
        logic                 eof;
    } entry_t;

    state_e                state_q, state_d;
    logic                  done_q, done_d;
    logic [ROW_WIDTH:0]    w_q, w_eff;
    logic [COL_WIDTH:0]    h_q, h_eff;
    logic [ROW_WIDTH-1:0]  x_q;
    logic [COL_WIDTH-1:0]  y_q;
    logic [ADDR_WIDTH-1:0] row_base_q;

    // Coordinates/flags of the read currently in flight, joined with rd_data on return.
    logic                  in_flight_q;
    logic [ROW_WIDTH-1:0]  fl_x_q;
    logic [COL_WIDTH-1:0]  fl_y_q;
    logic                  fl_eol_q, fl_eof_q;

    entry_t                fifo_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q;
    entry_t                head;

    logic                  dims_zero, accept, issue, pop, last_x, last_y;

    always_comb begin
        w_eff = img_width;
        h_eff = img_height;
`ifdef SCALE_READER_CLAMP_EN
        if (img_width > (ROW_WIDTH+1)'(ROW_SIZE)) w_eff = (ROW_WIDTH+1)'(ROW_SIZE);
        if (img_height > (COL_WIDTH+1)'(COL_SIZE)) h_eff = (COL_WIDTH+1)'(COL_SIZE);
`endif
        dims_zero = (w_eff == '0) || (h_eff == '0);
        accept    = (state_q == StIdle) && start && !dims_zero;
        head      = fifo_q[rd_ptr_q];
        pop       = (count_q != 2'd0) && bus.out_ready;
        // Credit: entries plus in-flight read after this cycle's pop must leave a free slot.
        issue     = (state_q == StRun) &&
                    (({1'b0, count_q} + {2'b0, in_flight_q}) < (3'd2 + {2'b0, pop}));
        last_x    = ({1'b0, x_q} == w_q - (ROW_WIDTH+1)'(1));
        last_y    = ({1'b0, y_q} == h_q - (COL_WIDTH+1)'(1));

        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && dims_zero) done_d = 1'b1;
                else if (start)         state_d = StRun;
            end
            StRun: begin
                if (issue && last_x && last_y) state_d = StDrain;
            end
            StDrain: begin
                if (pop && head.eof) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q         <= '0;
            h_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            in_flight_q <= 1'b0;
            fl_x_q      <= '0;
            fl_y_q      <= '0;
            fl_eol_q    <= 1'b0;
            fl_eof_q    <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            if (accept) begin
                w_q        <= w_eff;
                h_q        <= h_eff;
                x_q        <= '0;
                y_q        <= '0;
                row_base_q <= '0;
            end else if (issue) begin
                if (last_x) begin
                    x_q        <= '0;
                    y_q        <= y_q + COL_WIDTH'(1);
                    row_base_q <= row_base_q + ADDR_WIDTH'(ROW_SIZE);
                end else begin
                    x_q <= x_q + ROW_WIDTH'(1);
                end
            end

            in_flight_q <= issue;
            if (issue) begin
                fl_x_q   <= x_q;
                fl_y_q   <= y_q;
                fl_eol_q <= last_x;
                fl_eof_q <= last_x && last_y;
            end

            if (in_flight_q) begin
                fifo_q[wr_ptr_q] <= '{pixel: bus.rd_data, x: fl_x_q, y: fl_y_q,
                                      eol: fl_eol_q, eof: fl_eof_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, in_flight_q} - {1'b0, pop};
        end
    end

    assign bus.rd_en     = issue;
    assign bus.rd_addr   = row_base_q + ADDR_WIDTH'(x_q);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_pixel = head.pixel;
    assign bus.out_x     = head.x;
    assign bus.out_y     = head.y;
    assign bus.out_eol   = head.eol;
    assign bus.out_eof   = head.eof;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
endmodule

// File: tb/tb_scale_cache_reader.sv
// Self-checking bench for scale_cache_reader: cache model returns addr[7:0], expected pixels
// come from a raster-order queue built from frame dimensions.
module tb_scale_cache_reader;
    localparam int unsigned ROW_SIZE   = 320;
    localparam int unsigned COL_SIZE   = 240;
    localparam int unsigned WORD_SIZE  = 8;
    localparam int unsigned ROW_WIDTH  = $clog2(ROW_SIZE);
    localparam int unsigned COL_WIDTH  = $clog2(COL_SIZE);
    localparam int unsigned ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE);

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [ROW_WIDTH:0] img_width;
    logic [COL_WIDTH:0] img_height;
    logic               busy;
    logic               done;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];

    scale_cache_reader_if #(
        .WORD_SIZE (WORD_SIZE),
        .ROW_WIDTH (ROW_WIDTH),
        .COL_WIDTH (COL_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) bus ();

    scale_cache_reader #(
        .ROW_SIZE (ROW_SIZE),
        .COL_SIZE (COL_SIZE),
        .WORD_SIZE(WORD_SIZE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .img_width (img_width),
        .img_height(img_height),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Synchronous cache model, one-cycle latency, word = low byte of address.
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [WORD_SIZE-1:0] p,
                                         input logic [ROW_WIDTH-1:0] x,
                                         input logic [COL_WIDTH-1:0] y,
                                         input logic eol, input logic eof);
        return 64'({p, x, y, eol, eof});
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_rd_addr"}, 64'(bus.rd_addr), 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_fields"}, pack(bus.out_pixel, bus.out_x, bus.out_y, bus.out_eol,
                                     bus.out_eof), 0);
    endtask

    // mode: 0 ready high, 1 ready 1-on/2-off, 2 random ready.
    task automatic run_frame(input int w, input int h, input int mode, input bit restart,
                             input int reset_at);
        int ew, eh, budget, pops, issues, first_valid, done_cycle;
        bit stalled, saw_busy, finished, rdy;
        logic [63:0] held, cur;
        exp_q.delete();
        ew = w;
        eh = h;
`ifdef SCALE_READER_CLAMP_EN
        if (ew > int'(ROW_SIZE)) ew = ROW_SIZE;
        if (eh > int'(COL_SIZE)) eh = COL_SIZE;
`endif
        for (int y = 0; y < eh; y++) begin
            for (int x = 0; x < ew; x++) begin
                int unsigned a;
                a = (y * ROW_SIZE + x) % (1 << ADDR_WIDTH);
                exp_q.push_back(pack(WORD_SIZE'(a), ROW_WIDTH'(x), COL_WIDTH'(y),
                                     x == ew - 1, (x == ew - 1) && (y == eh - 1)));
            end
        end
        budget      = 4 * ew * eh + 50;
        img_width   = (ROW_WIDTH+1)'(w);
        img_height  = (COL_WIDTH+1)'(h);
        start       = 1'b1;
        pops        = 0;
        issues      = 0;
        first_valid = -1;
        done_cycle  = -1;
        stalled     = 1'b0;
        saw_busy    = 1'b0;
        finished    = 1'b0;
        held        = '0;
        for (int t = 0; t < budget && !finished; t++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (t % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            #1;
            cur = pack(bus.out_pixel, bus.out_x, bus.out_y, bus.out_eol, bus.out_eof);
            if (stalled) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_fields", cur, held);
            end
            stalled = bus.out_valid && !rdy;
            held    = cur;
            if (bus.out_valid && first_valid < 0) first_valid = t;
            if (mode == 0 && t == 1 && ew * eh != 0) begin
                check("busy_c1", busy, 1);
                check("rd_en_c1", bus.rd_en, 1);
                check("rd_addr_c1", 64'(bus.rd_addr), 0);
            end
            if (bus.rd_en) issues++;
            if (bus.out_valid && rdy) begin
                if (exp_q.size() == 0) check("extra_pixel", 1, 0);
                else check($sformatf("pixel%0d", pops), cur, exp_q.pop_front());
                pops++;
            end
            check("occupancy_le_2", (issues - pops) <= 2, 1);
            if (busy) saw_busy = 1'b1;
            if (reset_at >= 0 && pops == reset_at) reset = 1'b1;
            if (restart && t == 5) begin
                start      = 1'b1;
                img_width  = 2;
                img_height = 2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (reset) begin
                reset = 1'b0;
                check_reset_vals("mid_reset");
                finished = 1'b1;
            end else if (done) begin
                done_cycle = t + 1;
                finished   = 1'b1;
            end
        end
        if (reset_at < 0) begin
            check("done_seen", done_cycle >= 0, 1);
            check("pixels_left", exp_q.size(), 0);
            check("read_count", issues, ew * eh);
            check("busy_at_done", busy, 0);
            if (ew * eh == 0) begin
                check("zero_done_cycle", done_cycle, 1);
                check("zero_no_busy", saw_busy, 0);
            end else if (mode == 0) begin
                check("done_cycle", done_cycle, ew * eh + 3);
                check("first_valid_cycle", first_valid, 3);
            end
            if (restart) begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    check("restart_ignored", {busy, bus.out_valid}, 0);
                end
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        img_width     = '0;
        img_height    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_vals("reset");

        run_frame(4, 3, 0, 1'b0, -1);
        run_frame(4, 3, 1, 1'b0, -1);
        run_frame(0, 5, 0, 1'b0, -1);
        run_frame(4, 3, 0, 1'b1, -1);
        run_frame(4, 3, 0, 1'b0, 5);
        run_frame(4, 3, 0, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(1, 24)), int'($urandom_range(1, 5)), 2, 1'b0, -1);
        end
        run_frame(320, 2, 2, 1'b0, -1);
`ifdef SCALE_READER_CLAMP_EN
        run_frame(400, 10, 0, 1'b0, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
